// File: rtl/frame_update_scheduler_if.sv
// Request/acknowledge bundle between the frame scheduler and the five game-logic update units.
// The master side is the scheduler; the slave side is the datapath.
interface frame_update_scheduler_if;
  logic [4:0] phase_req;
  logic [4:0] phase_ack;
  logic       march_en;

  modport master (
    output phase_req,
    output march_en,
    input  phase_ack
  );

  modport slave (
    input  phase_req,
    input  march_en,
    output phase_ack
  );
endinterface

// File: rtl/frame_update_scheduler.sv
// Per-frame sequencer issuing one-hot update requests to player, shots, invaders, collide, score.
// Optional macro SCHED_PAUSE_EN adds a pause input that blocks new frames from starting.
module frame_update_scheduler #(
  parameter int unsigned MARCH_DIV_MAX = 32,
  parameter int unsigned MARCH_DIV_MIN = 2,
  parameter int unsigned ACK_TIMEOUT   = 255,
  parameter int unsigned INV_W         = 6
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 frame_tick,
  input  logic [1:0]           game_state,
  input  logic [INV_W-1:0]     invaders_left,
  input  logic                 clear_err,
`ifdef SCHED_PAUSE_EN
  input  logic                 pause,
`endif
  frame_update_scheduler_if.master upd,
  output logic                 busy,
  output logic                 overrun,
  output logic                 timeout_err,
  output logic [15:0]          frame_count
);

  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned MW = $clog2(MARCH_DIV_MAX + 1);
  localparam logic [TW-1:0] TmoLast = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StPlayer, StShots, StInvaders, StCollide, StScore, StDone
  } state_e;

  state_e        state_q;
  logic [4:0]    req_q;
  logic          march_en_q;
  logic          busy_q;
  logic          overrun_q;
  logic          timeout_err_q;
  logic [15:0]   frame_count_q;
  logic [MW-1:0] march_cnt_q;
  logic          march_due_q;
  logic [TW-1:0] tmo_cnt_q;

  logic          pause_act;
  logic          playing;
  logic [31:0]   inv_ext;
  logic [31:0]   div;
  logic [31:0]   cnt_inc;
  logic          march_hit;
  logic          ack_hit;
  logic          to_hit;
  logic          in_phase;
  logic          phase_go;
  state_e        adv_state;
  logic [4:0]    adv_req;
  logic          adv_march;

`ifdef SCHED_PAUSE_EN
  assign pause_act = pause;
`else
  assign pause_act = 1'b0;
`endif

  always_comb begin
    playing = (game_state == 2'b01);
    inv_ext = 32'(invaders_left);
    if (inv_ext < MARCH_DIV_MIN) begin
      div = MARCH_DIV_MIN;
    end else if (inv_ext > MARCH_DIV_MAX) begin
      div = MARCH_DIV_MAX;
    end else begin
      div = inv_ext;
    end
    cnt_inc   = 32'(march_cnt_q) + 32'd1;
    march_hit = (cnt_inc >= div);

    // Only the unit's own ack bit matters; a skipped phase has no request so it cannot match.
    ack_hit  = |(upd.phase_ack & req_q);
    to_hit   = (|req_q) && (tmo_cnt_q == TmoLast);
    in_phase = (state_q != StIdle) && (state_q != StDone);
    phase_go = ack_hit || to_hit || ((state_q == StInvaders) && !march_due_q);

    adv_state = StIdle;
    adv_req   = 5'b00000;
    adv_march = 1'b0;
    unique case (state_q)
      StPlayer: begin
        adv_state = StShots;
        adv_req   = 5'b00010;
      end
      StShots: begin
        adv_state = StInvaders;
        adv_req   = march_due_q ? 5'b00100 : 5'b00000;
        adv_march = march_due_q;
      end
      StInvaders: begin
        adv_state = StCollide;
        adv_req   = 5'b01000;
      end
      StCollide: begin
        adv_state = StScore;
        adv_req   = 5'b10000;
      end
      StScore: begin
        adv_state = StDone;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      req_q         <= 5'b00000;
      march_en_q    <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      frame_count_q <= 16'd0;
      march_cnt_q   <= '0;
      march_due_q   <= 1'b0;
      tmo_cnt_q     <= '0;
    end else begin
      if (frame_tick && (state_q != StIdle)) begin
        overrun_q <= 1'b1;
      end else if (clear_err) begin
        overrun_q <= 1'b0;
      end

      if (in_phase && playing && to_hit && !ack_hit) begin
        timeout_err_q <= 1'b1;
      end else if (clear_err) begin
        timeout_err_q <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          if (playing && frame_tick && !pause_act) begin
            state_q    <= StPlayer;
            req_q      <= 5'b00001;
            march_en_q <= 1'b0;
            busy_q     <= 1'b1;
            tmo_cnt_q  <= '0;
            if (march_hit) begin
              march_due_q <= 1'b1;
              march_cnt_q <= '0;
            end else begin
              march_due_q <= 1'b0;
              march_cnt_q <= MW'(cnt_inc);
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          if (playing) begin
            frame_count_q <= frame_count_q + 16'd1;
          end
        end
        default: begin
          if (!playing) begin
            // Abandon the frame: no DONE, no frame count, march counter untouched.
            state_q    <= StIdle;
            req_q      <= 5'b00000;
            march_en_q <= 1'b0;
            busy_q     <= 1'b0;
          end else if (phase_go) begin
            state_q    <= adv_state;
            req_q      <= adv_req;
            march_en_q <= adv_march;
            tmo_cnt_q  <= '0;
          end else if (|req_q) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
      endcase

      // Start screen keeps the game counters pinned to zero.
      if (game_state == 2'b00) begin
        march_cnt_q   <= '0;
        frame_count_q <= 16'd0;
      end
    end
  end

  assign upd.phase_req = req_q;
  assign upd.march_en  = march_en_q;
  assign busy          = busy_q;
  assign overrun       = overrun_q;
  assign timeout_err   = timeout_err_q;
  assign frame_count   = frame_count_q;

endmodule

// File: doc/frame_update_scheduler.md
Name: frame_update_scheduler

Overview:
- Per-frame sequencer for game-logic updates.
- On each frame_tick during PLAYING, issues one-hot req/ack handshakes in a fixed order to five update units: player move, shot move, invader march, collision, score.
- Sits between the VGA frame_tick source and the game-logic datapath.
- Paces the invader march with a divider that speeds up as invaders die; flags overruns and unit timeouts.

Parameters:
MARCH_DIV_MAX, 32, slowest march divisor in frames
MARCH_DIV_MIN, 2, fastest march divisor in frames
ACK_TIMEOUT, 255, cycles a phase request may stay unacknowledged
INV_W, 6, width of invaders_left

Ports:
clk  in  1  game clock
reset_n  in  1  asynchronous active-low reset
frame_tick  in  1  single-cycle pulse, synchronous to clk
game_state  in  2  00 start, 01 playing, 10 over, 11 win
invaders_left  in  INV_W  live invader count
phase_ack  in  5  per-phase acknowledge, same bit order as phase_req
clear_err  in  1  clears sticky flags
phase_req  out  5  one-hot request: [0] PLAYER, [1] SHOTS, [2] INVADERS, [3] COLLIDE, [4] SCORE
march_en  out  1  high while phase_req[2] is high
busy  out  1  high in any state other than IDLE
overrun  out  1  sticky: frame_tick arrived while busy
timeout_err  out  1  sticky: a phase timed out
frame_count  out  16  completed frames, wraps

Behaviour:
- Reset (async, reset_n=0):
  - state IDLE.
  - All outputs 0.
  - march_cnt 0, march_due 0, timeout counter 0.
- States: IDLE -> PLAYER -> SHOTS -> INVADERS -> COLLIDE -> SCORE -> DONE -> IDLE.
- Start: in IDLE, frame_tick=1 and game_state=01 → next edge enters PLAYER.
- Frame-start march update (same edge as PLAYER entry):
  - div = clamp(invaders_left, MARCH_DIV_MIN, MARCH_DIV_MAX).
  - If march_cnt+1 >= div: march_due=1, march_cnt=0.
  - Otherwise: march_due=0, march_cnt+1.
- Phase states:
  - Registered phase_req has exactly its bit high from state entry.
  - The unit's own ack bit sampled high → req cleared at that edge, advance; the next phase's req rises on the same edge.
  - Non-matching ack bits are ignored.
  - Minimum one cycle per phase.
- INVADERS with march_due=0: no request, one cycle, advance.
- Timeout:
  - Counter clears on phase entry and counts cycles with req high.
  - After ACK_TIMEOUT cycles with no ack: req drops, timeout_err=1, advance.
  - Ack on the timeout cycle counts as a normal ack; no error.
- DONE: one cycle; frame_count+1 (mod 2^16); then IDLE.
- frame_tick while not IDLE (DONE included): tick dropped, overrun=1.
- game_state ≠ 01 in any non-IDLE state:
  - Next edge: phase_req=0, state IDLE.
  - No DONE, no frame_count increment.
  - march_cnt held.
- game_state=00: march_cnt and frame_count held at 0; frame_tick ignored.
- game_state 10 or 11 in IDLE: frame_tick ignored, no overrun.
- clear_err=1 clears overrun and timeout_err. Simultaneous set and clear → set wins.
- busy = (state ≠ IDLE), registered.

Optional Feature:
- Macro: SCHED_PAUSE_EN.
- Defined:
  - Adds input port pause (1 bit).
  - While pause=1, frame_tick in IDLE is ignored: no start, no overrun, march_cnt frozen.
  - A sequence already in progress completes normally.
  - frame_tick while busy still sets overrun.
- Undefined: port absent; behaviour identical to pause=0.

Test Plan:
1. reset_n=0 mid-sequence (state SHOTS) → all outputs 0 immediately; after release, busy=0, frame_count=0.
2. game_state=01, invaders_left=40, acks one cycle after each req; frames 1-31 → phase_req 00001, 00010, 01000, 10000 (INVADERS skipped); frame 32 includes 00100 with march_en=1; frame_count=32.
3. invaders_left=3, 6 frames → march_en in frames 3 and 6 only; invaders_left=0, 4 frames → march in frames 2 and 4 (clamped to 2).
4. Withhold SHOTS ack → phase_req=00010 for exactly 255 cycles, then timeout_err=1 and next phase requested; ack on cycle 255 → no error.
5. frame_tick pulse during COLLIDE → overrun=1, frame_count +1 only; clear_err with a simultaneous overrun event → overrun stays 1.
6. game_state 01→10 while phase_req=00010 → next edge phase_req=0, busy=0, frame_count unchanged; later frame_tick ignored, overrun=0.
